cache_ro_nway: RTL and testbench

//  Parametrised N-way set-associative read-only (instruction) cache for the MIPS core.

---
 rtl/cache_ro_nway.sv | 169 ++++++++++++++++
 tb/tb_cache_ro_nway.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ro_nway.sv
// N-way set-associative read-only instruction cache with line refill over a req/ack port.
// Tags and lines live in per-way synchronous-read arrays; valid bits are flops so flush is one edge.
module cache_ro_nway #(
    parameter int BLOCK_WIDTH = 3,
    parameter int INDEX_WIDTH = 5,
    parameter int WAYS_LOG2   = 3
) (
    input  logic        i_ck,
    input  logic        i_rb,
    input  logic [29:0] i_cache_addr,
    input  logic        i_cache_req,
    output logic [31:0] o_cache_data,
    output logic        o_cache_ack,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic [29:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data
);
    localparam int TAG_WIDTH = 30 - BLOCK_WIDTH - INDEX_WIDTH;
    localparam int WORDS     = 1 << BLOCK_WIDTH;
    localparam int WAYS      = 1 << WAYS_LOG2;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int RR_W      = (WAYS_LOG2 > 0) ? WAYS_LOG2 : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, REREAD} state_t;

    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
    logic [BLOCK_WIDTH-1:0] offset;
    assign {tag, index, offset} = i_cache_addr;

    state_t                     state_reg;
    logic [WAYS-1:0][SETS-1:0]  valid_reg;
    logic [INDEX_WIDTH-1:0]     idx_reg;
    logic [BLOCK_WIDTH-1:0]     cnt_reg;
    logic [RR_W-1:0]            rr_reg;
    logic [RR_W-1:0]            victim_reg;
    logic                       evict_full_reg;
    logic                       flush_pend_reg;
    logic [WORDS-1:0][31:0]     line_buf_reg;

    logic [WAYS-1:0]            hit_way;
    logic [WAYS-1:0][31:0]      way_word;
    logic [31:0]                hit_data;
    logic [RR_W-1:0]            victim_next;
    logic                       all_valid;
    logic                       lookup_ok;
    logic                       miss;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_WIDTH-1:0]   tag_mem [SETS];
        logic [WORDS-1:0][31:0] line_mem [SETS];
        logic [TAG_WIDTH-1:0]   tag_rd_reg;
        logic [WORDS-1:0][31:0] line_rd_reg;
        logic                   we;

        // Gated by reset so an aborted refill never lands in the arrays.
        assign we = i_rb && (state_reg == WRITE) && (victim_reg == RR_W'(gi));

        always_ff @(posedge i_ck) begin
            if (we) begin
                tag_mem[index]  <= tag;
                line_mem[index] <= line_buf_reg;
            end
            tag_rd_reg  <= tag_mem[index];
            line_rd_reg <= line_mem[index];
        end

        assign hit_way[gi]  = valid_reg[gi][idx_reg] && (tag_rd_reg == tag);
        assign way_word[gi] = hit_way[gi] ? line_rd_reg[offset] : 32'h0;
    end

    always_comb begin
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_data = hit_data | way_word[w];
        end
    end

    // Lowest-numbered invalid way wins; round-robin only when the set is full.
    always_comb begin
        victim_next = rr_reg;
        all_valid   = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[w][idx_reg]) begin
                victim_next = RR_W'(w);
                all_valid   = 1'b0;
            end
        end
    end

    assign lookup_ok    = i_cache_req && (index == idx_reg) && (state_reg == IDLE) && !flush_pend_reg;
    assign miss         = lookup_ok && !(|hit_way);
    assign o_cache_ack  = lookup_ok && (|hit_way) && !i_flush;
    assign o_cache_data = o_cache_ack ? hit_data : 32'h0;
    assign o_mem_req    = (state_reg == FILL);
    assign o_mem_addr   = {i_cache_addr[29:BLOCK_WIDTH], cnt_reg};
    assign o_busy       = (state_reg != IDLE) || flush_pend_reg;

    always_ff @(posedge i_ck) begin
        if (state_reg == FILL && i_mem_ack) begin
            line_buf_reg[cnt_reg] <= i_mem_data;
        end
    end

    always_ff @(posedge i_ck) begin
        if (!i_rb) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            rr_reg         <= '0;
            victim_reg     <= '0;
            evict_full_reg <= 1'b0;
            flush_pend_reg <= 1'b0;
        end else begin
            idx_reg <= index;
            case (state_reg)
                IDLE: begin
                    if (i_flush) begin
                        valid_reg <= '0;
                    end
                    if (miss) begin
                        state_reg      <= FILL;
                        victim_reg     <= victim_next;
                        evict_full_reg <= all_valid;
                    end
                end
                FILL: begin
                    if (i_flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    if (i_mem_ack) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (&cnt_reg) begin
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (i_flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    if (!flush_pend_reg) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (victim_reg == RR_W'(w)) begin
                                valid_reg[w][index] <= 1'b1;
                            end
                        end
                    end
                    if (evict_full_reg && WAYS_LOG2 > 0) begin
                        rr_reg <= rr_reg + 1'b1;
                    end
                    state_reg <= REREAD;
                end
                default: begin
                    // A flush seen anywhere during the refill is applied here, as the FSM returns to IDLE.
                    if (flush_pend_reg || i_flush) begin
                        valid_reg      <= '0;
                        flush_pend_reg <= 1'b0;
                    end
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ro_nway.sv
// Bench for cache_ro_nway: directed table on an 8-way/8-word instance, hand sequences for flush and
// reset during refill, and random streams on 1-way and 4-way/4-word instances against a set model.
module tb_cache_ro_nway;
    logic        clk;
    logic        c_rb    [3];
    logic [29:0] c_addr  [3];
    logic        c_req   [3];
    logic [31:0] c_data  [3];
    logic        c_ack   [3];
    logic        c_flush [3];
    logic        c_busy  [3];
    logic        c_mreq  [3];
    logic [29:0] c_maddr [3];
    logic        c_mack  [3];
    logic [31:0] c_mdata [3];
    int          acc     [3];

    int n_vec = 0;
    int n_mis = 0;
    int prev_idx0 = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        cache_ro_nway #(
            .BLOCK_WIDTH (gi == 0 ? 3 : 2),
            .INDEX_WIDTH (gi == 0 ? 5 : 2),
            .WAYS_LOG2   (gi == 0 ? 3 : (gi == 1 ? 0 : 2))
        ) dut (
            .i_ck         (clk),
            .i_rb         (c_rb[gi]),
            .i_cache_addr (c_addr[gi]),
            .i_cache_req  (c_req[gi]),
            .o_cache_data (c_data[gi]),
            .o_cache_ack  (c_ack[gi]),
            .i_flush      (c_flush[gi]),
            .o_busy       (c_busy[gi]),
            .o_mem_req    (c_mreq[gi]),
            .o_mem_addr   (c_maddr[gi]),
            .i_mem_ack    (c_mack[gi]),
            .i_mem_data   (c_mdata[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(int k, logic [29:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ (32'(k) << 28) ^ 32'h00C0FFEE;
    endfunction

    function automatic int bw_of(int k);
        return (k == 0) ? 3 : 2;
    endfunction

    // Memory: instance 0 answers every cycle, the others stall at random.
    initial begin
        for (int k = 0; k < 3; k++) begin
            c_mack[k]  = 1'b0;
            c_mdata[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (c_mreq[k] && (k == 0 || $urandom_range(0, 2) != 0)) begin
                    c_mack[k]  = 1'b1;
                    c_mdata[k] = mem_word(k, c_maddr[k]);
                end else begin
                    c_mack[k]  = 1'b0;
                    c_mdata[k] = $urandom;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) acc[k] = 0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (c_mreq[k] && c_mack[k]) acc[k] = acc[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input int k, input logic [29:0] a, output bit miss, output logic [31:0] d,
                          output int lat, output logic [29:0] first_ma, output bit to);
        miss = 0; d = '0; lat = 0; to = 1; first_ma = '0;
        @(negedge clk);
        c_addr[k] = a;
        c_req[k]  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            lat++;
            if (c_mreq[k] && !miss) begin
                miss     = 1;
                first_ma = c_maddr[k];
            end
            if (c_ack[k]) begin
                d  = c_data[k];
                to = 0;
                break;
            end
        end
        @(negedge clk);
        c_req[k] = 1'b0;
    endtask

    task automatic run_vec(input int k, input logic [29:0] a, input bit exp_miss, input string tag);
        bit          miss, to;
        logic [31:0] d;
        int          lat, exp_lat;
        logic [29:0] fma, base;
        do_req(k, a, miss, d, lat, fma, to);
        base = (a >> bw_of(k)) << bw_of(k);
        $display("txn %s k=%0d addr=%h miss=%0d data=%h lat=%0d", tag, k, a, miss, d, lat);
        check({tag, " timeout"}, 64'(to), 64'd0);
        check({tag, " miss"}, 64'(miss), 64'(exp_miss));
        check({tag, " data"}, 64'(d), 64'(mem_word(k, a)));
        if (exp_miss) check({tag, " first mem addr"}, 64'(fma), 64'(base));
        if (k == 0) begin
            exp_lat = !exp_miss ? 1 : ((int'(a[7:3]) == prev_idx0) ? 11 : 12);
            check({tag, " latency"}, 64'(lat), 64'(exp_lat));
            prev_idx0 = int'(a[7:3]);
        end
    endtask

    task automatic pulse_flush(input int k);
        @(negedge clk); c_flush[k] = 1'b1;
        @(negedge clk); c_flush[k] = 1'b0;
    endtask

    // Reference: sets of {valid, tag} per way, refilled by lowest-free-way then round-robin.
    bit mval [3][4][4];
    int mtag [3][4][4];
    int mrr  [3];

    function automatic bit model_access(int k, logic [29:0] a);
        int nways = (k == 1) ? 1 : 4;
        int s = int'(a[3:2]);
        int t = int'(a[29:4]);
        int v = -1;
        for (int w = 0; w < nways; w++) if (mval[k][s][w] && mtag[k][s][w] == t) return 1'b1;
        for (int w = 0; w < nways; w++) if (!mval[k][s][w] && v < 0) v = w;
        if (v < 0) begin
            v = mrr[k];
            mrr[k] = (mrr[k] + 1) % nways;
        end
        mval[k][s][v] = 1'b1;
        mtag[k][s][v] = t;
        return 1'b0;
    endfunction

    function automatic logic [29:0] mk(int t, int i, int o);
        return 30'((t << 8) | (i << 3) | o);
    endfunction

    typedef struct {
        logic [29:0] addr;
        bit          flush;
        bit          exp_miss;
    } vec_t;

    initial begin
        vec_t        tbl [21];
        logic [29:0] a;
        bit          saw, ended;
        int          base_acc, hits_dut, hits_mod;

        tbl[0]  = '{30'h100, 1'b0, 1'b1};
        tbl[1]  = '{30'h105, 1'b0, 1'b0};
        tbl[2]  = '{30'h107, 1'b0, 1'b0};
        for (int t = 1; t <= 8; t++) tbl[2 + t] = '{mk(t, 5, t % 8), 1'b0, 1'b1};
        tbl[11] = '{mk(1, 5, 2),  1'b0, 1'b0};
        tbl[12] = '{mk(9, 5, 0),  1'b0, 1'b1};
        tbl[13] = '{mk(10, 5, 0), 1'b0, 1'b1};
        tbl[14] = '{mk(3, 5, 1),  1'b0, 1'b0};
        tbl[15] = '{mk(1, 5, 0),  1'b0, 1'b1};
        tbl[16] = '{mk(2, 5, 0),  1'b0, 1'b1};
        tbl[17] = '{mk(9, 5, 7),  1'b0, 1'b0};
        tbl[18] = '{30'h100,      1'b0, 1'b0};
        tbl[19] = '{30'h100,      1'b1, 1'b1};
        tbl[20] = '{mk(9, 5, 0),  1'b0, 1'b1};

        for (int k = 0; k < 3; k++) begin
            c_rb[k] = 1'b0; c_req[k] = 1'b0; c_flush[k] = 1'b0; c_addr[k] = '0; mrr[k] = 0;
            for (int s = 0; s < 4; s++) for (int w = 0; w < 4; w++) mval[k][s][w] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ack k%0d", k),  64'(c_ack[k]),  64'd0);
            check($sformatf("reset mreq k%0d", k), 64'(c_mreq[k]), 64'd0);
            check($sformatf("reset busy k%0d", k), 64'(c_busy[k]), 64'd0);
            check($sformatf("reset data k%0d", k), 64'(c_data[k]), 64'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) c_rb[k] = 1'b1;

        for (int i = 0; i < 21; i++) begin
            if (tbl[i].flush) pulse_flush(0);
            run_vec(0, tbl[i].addr, tbl[i].exp_miss, $sformatf("tbl%0d", i));
        end

        // Flush while refilling, with the request dropped: busy holds until the refill retires.
        a = mk(20, 3, 0);
        @(negedge clk); c_addr[0] = a; c_req[0] = 1'b1;
        saw = 0;
        for (int i = 0; i < 50 && !saw; i++) begin
            @(posedge clk); #1;
            if (c_mreq[0]) saw = 1;
        end
        check("flushfill mem_req seen", 64'(saw), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); c_flush[0] = 1'b1; c_req[0] = 1'b0;
        @(negedge clk); c_flush[0] = 1'b0;
        @(posedge clk); #1;
        check("flushfill busy", 64'(c_busy[0]), 64'd1);
        ended = 0;
        for (int i = 0; i < 50 && !ended; i++) begin
            @(posedge clk); #1;
            if (!c_busy[0]) ended = 1;
        end
        check("flushfill busy released", 64'(ended), 64'd1);
        prev_idx0 = 3;
        run_vec(0, a, 1'b1, "flushfill refetch");
        run_vec(0, 30'h100, 1'b1, "flushfill old line");

        // Reset while the third refill word is on the bus.
        a = mk(30, 1, 0);
        @(negedge clk); c_addr[0] = a; c_req[0] = 1'b1;
        base_acc = acc[0];
        for (int i = 0; i < 50 && (acc[0] - base_acc) < 2; i++) begin
            @(posedge clk); #1;
        end
        check("rstfill words before reset", 64'(acc[0] - base_acc), 64'd2);
        @(negedge clk); c_rb[0] = 1'b0;
        @(posedge clk); #1;
        check("rstfill mem_req", 64'(c_mreq[0]), 64'd0);
        check("rstfill busy", 64'(c_busy[0]), 64'd0);
        @(negedge clk); c_rb[0] = 1'b1; c_req[0] = 1'b0;
        prev_idx0 = 1;
        run_vec(0, a, 1'b1, "rstfill refetch");
        run_vec(0, 30'h100, 1'b1, "rstfill old line");

        // Random streams on the small configurations.
        for (int k = 1; k < 3; k++) begin
            hits_dut = 0; hits_mod = 0;
            for (int n = 0; n < 80; n++) begin
                bit exp_hit;
                if ($urandom_range(0, 15) == 0) begin
                    pulse_flush(k);
                    for (int s = 0; s < 4; s++) for (int w = 0; w < 4; w++) mval[k][s][w] = 1'b0;
                end
                a = 30'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
                exp_hit = model_access(k, a);
                if (exp_hit) hits_mod++;
                begin
                    bit          miss, to;
                    logic [31:0] d;
                    int          lat;
                    logic [29:0] fma;
                    do_req(k, a, miss, d, lat, fma, to);
                    $display("txn rnd k=%0d addr=%h miss=%0d data=%h lat=%0d", k, a, miss, d, lat);
                    if (!miss && !to) hits_dut++;
                    check($sformatf("rnd k%0d #%0d timeout", k, n), 64'(to), 64'd0);
                    check($sformatf("rnd k%0d #%0d miss", k, n), 64'(miss), 64'(!exp_hit));
                    check($sformatf("rnd k%0d #%0d data", k, n), 64'(d), 64'(mem_word(k, a)));
                end
            end
            check($sformatf("rnd k%0d hit count", k), 64'(hits_dut), 64'(hits_mod));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
